// File: rtl/axi4_wr_resp_merge_pkg.sv
// rtl/axi4_wr_resp_merge_pkg.sv - shared response types and merge helpers
package axi4_wr_resp_merge_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  // Running summary of the sub-burst responses seen so far.
  typedef struct packed {
    logic any_dec;
    logic any_slv;
    logic all_ex;
  } resp_acc_t;

  // Neutral accumulator: nothing bad seen yet, every response so far exclusive.
  localparam resp_acc_t ACC_INIT = '{any_dec: 1'b0, any_slv: 1'b0, all_ex: 1'b1};

  function automatic resp_acc_t acc_update(input resp_acc_t acc, input axi_resp_e r);
    resp_acc_t nxt;
    nxt.any_dec = acc.any_dec | (r == DECERR);
    nxt.any_slv = acc.any_slv | (r == SLVERR);
    nxt.all_ex  = acc.all_ex  & (r == EXOKAY);
    return nxt;
  endfunction

  // Error severity wins; exclusive only survives if every sub-burst was exclusive.
  function automatic axi_resp_e merge_resp(input resp_acc_t acc);
    if (acc.any_dec)      return DECERR;
    else if (acc.any_slv) return SLVERR;
    else if (acc.all_ex)  return EXOKAY;
    else                  return OKAY;
  endfunction

endpackage

// File: rtl/axi4_wr_merge_cmd_fifo.sv
// rtl/axi4_wr_merge_cmd_fifo.sv - long-burst descriptor FIFO with registered occupancy
module axi4_wr_merge_cmd_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_req,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ready_q, ready_d;
  logic             push_ok, pop_ok;

  // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
  assign push_ok    = push_valid && ready_q;
  assign pop_ok     = pop_req && (count_q != '0);
  assign push_ready = ready_q;
  assign empty      = (count_q == '0);
  assign pop_data   = mem_q[rd_ptr_q];

  // Next pointers, occupancy and ready (ready is held low while in reset).
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    ready_d  = (count_d != CW'(DEPTH));
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  // Storage array; contents are meaningless while empty, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/axi4_wr_resp_merge.sv
// rtl/axi4_wr_resp_merge.sv - merges N sub-burst B responses into one B per long burst
module axi4_wr_resp_merge
  import axi4_wr_resp_merge_pkg::*;
#(
  parameter int IDSIZE = 4,
  parameter int CNT_W  = 8,
  parameter int DEPTH  = 4
) (
  input  logic              axi_aclk,
  input  logic              axi_aresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [IDSIZE-1:0] cmd_id,
  input  logic [CNT_W-1:0]  cmd_num,
  input  logic              sub_bvalid,
  output logic              sub_bready,
  input  logic [IDSIZE-1:0] sub_bid,
  input  logic [1:0]        sub_bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic [IDSIZE-1:0] bid,
  output logic [1:0]        bresp,
  output logic              err_id_mis
);

  typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_e;

  state_e            state_q, state_d;
  logic [IDSIZE-1:0] cur_id_q, cur_id_d;
  logic [CNT_W-1:0]  remain_q, remain_d;
  resp_acc_t         acc_q, acc_d;
  logic              sub_bready_q, sub_bready_d;
  logic              bvalid_q, bvalid_d;
  logic [IDSIZE-1:0] bid_q, bid_d;
  axi_resp_e         bresp_q, bresp_d;
  logic              err_q, err_d;

  logic              fifo_empty, pop, beat;
  logic [IDSIZE-1:0] head_id;
  logic [CNT_W-1:0]  head_num;

  axi4_wr_merge_cmd_fifo #(
    .WIDTH (IDSIZE + CNT_W),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk        (axi_aclk),
    .rst_n      (axi_aresetn),
    .push_valid (cmd_valid),
    .push_ready (cmd_ready),
    .push_data  ({cmd_id, cmd_num}),
    .pop_req    (pop),
    .pop_data   ({head_id, head_num}),
    .empty      (fifo_empty)
  );

  assign pop  = (state_q == IDLE) && !fifo_empty;
  assign beat = (state_q == COLLECT) && sub_bvalid && sub_bready_q;

  assign sub_bready = sub_bready_q;
  assign bvalid     = bvalid_q;
  assign bid        = bid_q;
  assign bresp      = bresp_q;
  assign err_id_mis = err_q;

  // Next-state and registered-output decode for the merge FSM.
  always_comb begin
    state_d      = state_q;
    cur_id_d     = cur_id_q;
    remain_d     = remain_q;
    acc_d        = acc_q;
    sub_bready_d = sub_bready_q;
    bvalid_d     = bvalid_q;
    bid_d        = bid_q;
    bresp_d      = bresp_q;
    err_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          cur_id_d     = head_id;
          remain_d     = (head_num == '0) ? CNT_W'(1) : head_num;
          acc_d        = ACC_INIT;
          sub_bready_d = 1'b1;
          state_d      = COLLECT;
        end
      end
      COLLECT: begin
        if (beat) begin
          acc_d    = acc_update(acc_q, axi_resp_e'(sub_bresp));
          remain_d = remain_q - CNT_W'(1);
          err_d    = (sub_bid != cur_id_q);
          if (remain_q == CNT_W'(1)) begin
            sub_bready_d = 1'b0;
            bvalid_d     = 1'b1;
            bid_d        = cur_id_q;
            bresp_d      = merge_resp(acc_d);
            state_d      = EMIT;
          end
        end
      end
      EMIT: begin
        if (bready) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, burst context and registered outputs.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q      <= IDLE;
      cur_id_q     <= '0;
      remain_q     <= '0;
      acc_q        <= ACC_INIT;
      sub_bready_q <= 1'b0;
      bvalid_q     <= 1'b0;
      bid_q        <= '0;
      bresp_q      <= OKAY;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_id_q     <= cur_id_d;
      remain_q     <= remain_d;
      acc_q        <= acc_d;
      sub_bready_q <= sub_bready_d;
      bvalid_q     <= bvalid_d;
      bid_q        <= bid_d;
      bresp_q      <= bresp_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_axi4_wr_resp_merge.sv
// tb/tb_axi4_wr_resp_merge.sv - directed self-checking bench for axi4_wr_resp_merge
module tb_axi4_wr_resp_merge;

  localparam int IDSIZE = 4;
  localparam int CNT_W  = 8;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [IDSIZE-1:0] cmd_id = '0;
  logic [CNT_W-1:0]  cmd_num = '0;
  logic              sub_bvalid = 1'b0;
  logic              sub_bready;
  logic [IDSIZE-1:0] sub_bid = '0;
  logic [1:0]        sub_bresp = '0;
  logic              bvalid;
  logic              bready = 1'b1;
  logic [IDSIZE-1:0] bid;
  logic [1:0]        bresp;
  logic              err_id_mis;

  int checks = 0;
  int failures = 0;

  axi4_wr_resp_merge #(
    .IDSIZE (IDSIZE),
    .CNT_W  (CNT_W),
    .DEPTH  (DEPTH)
  ) dut (
    .axi_aclk    (clk),
    .axi_aresetn (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_id      (cmd_id),
    .cmd_num     (cmd_num),
    .sub_bvalid  (sub_bvalid),
    .sub_bready  (sub_bready),
    .sub_bid     (sub_bid),
    .sub_bresp   (sub_bresp),
    .bvalid      (bvalid),
    .bready      (bready),
    .bid         (bid),
    .bresp       (bresp),
    .err_id_mis  (err_id_mis)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a descriptor and hold it until a rising edge sees cmd_ready high.
  task automatic push_cmd(input logic [IDSIZE-1:0] id, input logic [CNT_W-1:0] num);
    logic acc;
    acc = 1'b0;
    cmd_id = id;
    cmd_num = num;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      acc = cmd_ready;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("push_accept", {31'd0, acc}, 32'd1);
  endtask

  // Present one sub-burst response and hold it until it is taken.
  task automatic sub_beat(input logic [IDSIZE-1:0] id, input logic [1:0] resp);
    logic acc;
    acc = 1'b0;
    sub_bid = id;
    sub_bresp = resp;
    sub_bvalid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      acc = sub_bready;
      @(negedge clk);
    end
    sub_bvalid = 1'b0;
    chk("sub_accept", {31'd0, acc}, 32'd1);
  endtask

  initial begin
    // Reset
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_sub_bready", {31'd0, sub_bready}, 32'd0);
    chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
    chk("rst_bid", {28'd0, bid}, 32'd0);
    chk("rst_bresp", {30'd0, bresp}, 32'd0);
    chk("rst_err", {31'd0, err_id_mis}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("post_rst_sub_bready", {31'd0, sub_bready}, 32'd0);

    // 1: id=3, N=4, all OKAY
    push_cmd(4'd3, 8'd4);
    sub_beat(4'd3, 2'b00);
    sub_beat(4'd3, 2'b00);
    sub_beat(4'd3, 2'b00);
    chk("t1_bvalid_early", {31'd0, bvalid}, 32'd0);
    chk("t1_sub_bready_mid", {31'd0, sub_bready}, 32'd1);
    sub_beat(4'd3, 2'b00);
    chk("t1_bvalid", {31'd0, bvalid}, 32'd1);
    chk("t1_bid", {28'd0, bid}, 32'd3);
    chk("t1_bresp", {30'd0, bresp}, 32'd0);
    chk("t1_sub_bready_emit", {31'd0, sub_bready}, 32'd0);
    @(negedge clk);
    chk("t1_bvalid_drop", {31'd0, bvalid}, 32'd0);

    // 2a: OKAY, SLVERR, DECERR -> DECERR
    push_cmd(4'd1, 8'd3);
    sub_beat(4'd1, 2'b00);
    sub_beat(4'd1, 2'b10);
    sub_beat(4'd1, 2'b11);
    chk("t2a_bvalid", {31'd0, bvalid}, 32'd1);
    chk("t2a_bid", {28'd0, bid}, 32'd1);
    chk("t2a_bresp", {30'd0, bresp}, 32'd3);
    chk("t2a_err", {31'd0, err_id_mis}, 32'd0);
    @(negedge clk);
    // 2b: EXOKAY, OKAY -> OKAY
    push_cmd(4'd4, 8'd2);
    sub_beat(4'd4, 2'b01);
    sub_beat(4'd4, 2'b00);
    chk("t2b_bid", {28'd0, bid}, 32'd4);
    chk("t2b_bresp", {30'd0, bresp}, 32'd0);
    @(negedge clk);
    // 2c: EXOKAY, EXOKAY -> EXOKAY
    push_cmd(4'd6, 8'd2);
    sub_beat(4'd6, 2'b01);
    sub_beat(4'd6, 2'b01);
    chk("t2c_bid", {28'd0, bid}, 32'd6);
    chk("t2c_bresp", {30'd0, bresp}, 32'd1);
    @(negedge clk);
    // 2d: SLVERR, OKAY -> SLVERR
    push_cmd(4'd7, 8'd2);
    sub_beat(4'd7, 2'b10);
    sub_beat(4'd7, 2'b00);
    chk("t2d_bid", {28'd0, bid}, 32'd7);
    chk("t2d_bresp", {30'd0, bresp}, 32'd2);
    @(negedge clk);

    // 4: merged B held under backpressure
    bready = 1'b0;
    push_cmd(4'd9, 8'd2);
    sub_beat(4'd9, 2'b00);
    sub_beat(4'd9, 2'b01);
    for (int i = 0; i < 10; i++) begin
      chk("t4_bvalid_hold", {31'd0, bvalid}, 32'd1);
      chk("t4_bid_hold", {28'd0, bid}, 32'd9);
      chk("t4_bresp_hold", {30'd0, bresp}, 32'd0);
      chk("t4_sub_bready_hold", {31'd0, sub_bready}, 32'd0);
      @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk);
    chk("t4_bvalid_release", {31'd0, bvalid}, 32'd0);

    // 5: N=0 treated as 1, mismatching sub_bid
    push_cmd(4'd2, 8'd0);
    sub_beat(4'd5, 2'b00);
    chk("t5_err_pulse", {31'd0, err_id_mis}, 32'd1);
    chk("t5_bvalid", {31'd0, bvalid}, 32'd1);
    chk("t5_bid", {28'd0, bid}, 32'd2);
    chk("t5_bresp", {30'd0, bresp}, 32'd0);
    @(negedge clk);
    chk("t5_err_clear", {31'd0, err_id_mis}, 32'd0);
    chk("t5_bvalid_drop", {31'd0, bvalid}, 32'd0);

    // 6: reset in the middle of a 4-beat collect
    push_cmd(4'd10, 8'd4);
    sub_beat(4'd10, 2'b00);
    sub_beat(4'd10, 2'b00);
    chk("t6_mid_sub_bready", {31'd0, sub_bready}, 32'd1);
    chk("t6_mid_bvalid", {31'd0, bvalid}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_sub_bready", {31'd0, sub_bready}, 32'd0);
    chk("t6_rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("t6_rst_bvalid", {31'd0, bvalid}, 32'd0);
    chk("t6_rst_bid", {28'd0, bid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_post_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("t6_fifo_empty_idle", {31'd0, sub_bready}, 32'd0);
      @(negedge clk);
    end

    // 3: fill the FIFO (first descriptor is popped straight away)
    push_cmd(4'd11, 8'd1);
    push_cmd(4'd12, 8'd1);
    push_cmd(4'd13, 8'd1);
    push_cmd(4'd14, 8'd1);
    push_cmd(4'd15, 8'd1);
    chk("t3_full_ready", {31'd0, cmd_ready}, 32'd0);
    cmd_id = 4'd0;
    cmd_num = 8'd1;
    cmd_valid = 1'b1;
    @(negedge clk);
    chk("t3_refuse_1", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    chk("t3_refuse_2", {31'd0, cmd_ready}, 32'd0);
    cmd_valid = 1'b0;
    sub_beat(4'd11, 2'b00);
    chk("t3_b11_bid", {28'd0, bid}, 32'd11);
    chk("t3_emit_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    chk("t3_idle_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    chk("t3_pop_frees", {31'd0, cmd_ready}, 32'd1);
    chk("t3_next_collect", {31'd0, sub_bready}, 32'd1);
    sub_beat(4'd12, 2'b00);
    chk("t3_b12_bid", {28'd0, bid}, 32'd12);
    sub_beat(4'd13, 2'b00);
    chk("t3_b13_bid", {28'd0, bid}, 32'd13);
    sub_beat(4'd14, 2'b00);
    chk("t3_b14_bid", {28'd0, bid}, 32'd14);
    sub_beat(4'd15, 2'b00);
    chk("t3_b15_bid", {28'd0, bid}, 32'd15);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_drained", {31'd0, sub_bready}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
